// File: rtl/imm_encoder_if.sv
// Request/response bundle for the immediate encoder.
// The slave modport is the encoder's view; the master modport is the
// requester/consumer view (a testbench or the surrounding datapath).
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  immgen_op;
    logic [63:0] imm_val;
    logic [31:0] base_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] inst;
    logic        range_err;

    modport master (
        output in_valid,
        output immgen_op,
        output imm_val,
        output base_inst,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  inst,
        input  range_err
    );

    modport slave (
        input  in_valid,
        input  immgen_op,
        input  imm_val,
        input  base_inst,
        input  out_ready,
        output in_ready,
        output out_valid,
        output inst,
        output range_err
    );
endinterface

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 64-bit immediate into the immediate fields of a
// RISC-V style instruction template (I/S/B/U/J formats) and flags immediates
// that the chosen format cannot represent.
//
// Two-stage valid/ready pipeline:
//   S1 - registers the request (op, immediate, template).
//   S2 - registers the encoded instruction and its range error.
// Each stage advances when it holds data and the stage after it is empty or
// emptying this cycle, giving one result per cycle with no back-pressure and
// room for two outstanding requests when the consumer stalls.
module imm_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    imm_encoder_if.slave         bus,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        OP_I = 3'b001,
        OP_S = 3'b010,
        OP_B = 3'b011,
        OP_U = 3'b100,
        OP_J = 3'b101
    } op_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_op_q,    s1_op_d;
    logic [63:0]          s1_imm_q,   s1_imm_d;
    logic [31:0]          s1_base_q,  s1_base_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [31:0]          inst_q,     inst_d;
    logic                 range_err_q, range_err_d;

    logic [ERR_CNT_W-1:0] err_cnt_q,  err_cnt_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic in_ready;
    logic in_fire;
    logic s1_adv;
    logic out_fire;

    // Stage-advance and transfer qualifiers.
    always_comb begin
        out_fire = s2_valid_q && bus.out_ready;
        s1_adv   = s1_valid_q && (!s2_valid_q || bus.out_ready);
        in_ready = !s1_valid_q || s1_adv;
        in_fire  = bus.in_valid && in_ready;
    end

    // ------------------------------------------------------------------
    // Encoder (operates on the S1 registers)
    // ------------------------------------------------------------------
    // An immediate fits a signed N-bit field when every bit from N-1 upward
    // is a copy of the sign bit.
    logic fits_12;   // imm[63:11] all equal
    logic fits_13;   // imm[63:12] all equal
    logic fits_21;   // imm[63:20] all equal
    logic u_low_nz;  // U immediates must have imm[43:0] clear

    assign fits_12  = (&s1_imm_q[63:11]) || (~|s1_imm_q[63:11]);
    assign fits_13  = (&s1_imm_q[63:12]) || (~|s1_imm_q[63:12]);
    assign fits_21  = (&s1_imm_q[63:20]) || (~|s1_imm_q[63:20]);
    assign u_low_nz = |s1_imm_q[43:0];

    logic [31:0] enc_inst;
    logic        enc_err;

    // Overlay the format's immediate fields onto the template; fields are
    // written even when the immediate is out of range (truncated bits).
    // NOTE: every output of a combinational block gets a default before the
    // case statement so no path leaves it unassigned and a latch is inferred.
    always_comb begin
        enc_inst = s1_base_q;
        enc_err  = 1'b0;
        case (s1_op_q)
            OP_I: begin
                enc_inst[31:20] = s1_imm_q[11:0];
                enc_err         = !fits_12;
            end
            OP_S: begin
                enc_inst[31:25] = s1_imm_q[11:5];
                enc_inst[11:7]  = s1_imm_q[4:0];
                enc_err         = !fits_12;
            end
            OP_B: begin
                enc_inst[31]    = s1_imm_q[12];
                enc_inst[30:25] = s1_imm_q[10:5];
                enc_inst[11:8]  = s1_imm_q[4:1];
                enc_inst[7]     = s1_imm_q[11];
                enc_err         = s1_imm_q[0] || !fits_13;
            end
            OP_U: begin
                enc_inst[31:12] = s1_imm_q[63:44];
                enc_err         = u_low_nz;
            end
            OP_J: begin
                enc_inst[31]    = s1_imm_q[20];
                enc_inst[30:21] = s1_imm_q[10:1];
                enc_inst[20]    = s1_imm_q[11];
                enc_inst[19:12] = s1_imm_q[19:12];
                enc_err         = s1_imm_q[0] || !fits_21;
            end
            default: begin
                // Unknown format: pass the template through, flag it.
                enc_inst = s1_base_q;
                enc_err  = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // S1: load on input transfer, empty when its contents move to S2.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_imm_d   = s1_imm_q;
        s1_base_d  = s1_base_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_op_d    = bus.immgen_op;
            s1_imm_d   = bus.imm_val;
            s1_base_d  = bus.base_inst;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2: capture the encoded result on advance; hold it while stalled so
    // inst/range_err stay stable until the consumer accepts.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        inst_d      = inst_q;
        range_err_d = range_err_q;
        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            inst_d      = enc_inst;
            range_err_d = enc_err;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    // Error counter: count delivered errored results, saturating at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_fire && range_err_q && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // Pipeline and counter registers; reset discards anything in flight.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of the others regardless of order.
    // NOTE: the datapath registers are reset too, because the visible outputs
    // (inst, range_err) must read zero while and after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 3'b000;
            s1_imm_q    <= 64'd0;
            s1_base_q   <= 32'd0;
            s2_valid_q  <= 1'b0;
            inst_q      <= 32'd0;
            range_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_imm_q    <= s1_imm_d;
            s1_base_q   <= s1_base_d;
            s2_valid_q  <= s2_valid_d;
            inst_q      <= inst_d;
            range_err_q <= range_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.inst      = inst_q;
    assign bus.range_err = range_err_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed format cases, stall/ordering,
// reset with requests in flight, error-counter saturation, and a randomized
// sweep scored against a range-based reference model and an immediate decoder.
module tb_imm_encoder;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    imm_encoder_if bus ();
    imm_encoder_if bus2 ();

    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;

    imm_encoder #(.ERR_CNT_W(16)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .err_cnt (err_cnt)
    );

    // Narrow-counter copy fed the same traffic, for the saturation check.
    imm_encoder #(.ERR_CNT_W(2)) dut_sat (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus2),
        .err_cnt (err_cnt2)
    );

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.immgen_op = bus.immgen_op;
    assign bus2.imm_val   = bus.imm_val;
    assign bus2.base_inst = bus.base_inst;
    assign bus2.out_ready = bus.out_ready;

    typedef struct {
        logic [31:0] inst;
        logic        err;
        logic [2:0]  op;
        logic [63:0] imm;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    int          exp_cnt2 = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst = 32'd0;
    logic        prev_err = 1'b0;
    logic        last_acc = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: representability as a signed value range, fields placed
    // per the format's bit map, template elsewhere.
    function automatic exp_t model(input logic [2:0] op, input logic [63:0] imm,
                                   input logic [31:0] base);
        exp_t   e;
        longint s;
        s     = longint'(imm);
        e.op  = op;
        e.imm = imm;
        e.err = 1'b0;
        e.inst = base;
        case (op)
            3'd1: begin
                e.err  = (s < -2048) || (s > 2047);
                e.inst = {imm[11:0], base[19:0]};
            end
            3'd2: begin
                e.err  = (s < -2048) || (s > 2047);
                e.inst = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            end
            3'd3: begin
                e.err  = (imm[0] == 1'b1) || (s < -4096) || (s > 4095);
                e.inst = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            end
            3'd4: begin
                e.err  = (imm % (64'd1 << 44)) != 64'd0;
                e.inst = {imm[63:44], base[11:0]};
            end
            3'd5: begin
                e.err  = (imm[0] == 1'b1) || (s < -1048576) || (s > 1048575);
                e.inst = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
            end
            default: begin
                e.err  = 1'b1;
                e.inst = base;
            end
        endcase
        return e;
    endfunction

    // Immediate generator (decoder) used for the round-trip check.
    function automatic logic [63:0] decode(input logic [2:0] op, input logic [31:0] i);
        case (op)
            3'd1: return {{52{i[31]}}, i[31:20]};
            3'd2: return {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3: return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: return {i[31:12], 44'd0};
            3'd5: return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] gen_imm(input logic [2:0] op);
        longint lim;
        longint v;
        int     k;
        k = $urandom_range(0, 3);
        if (op == 3'd4) begin
            if (k < 2)       return {20'($urandom), 44'd0};
            else if (k == 2) return {20'($urandom), 44'd1 << $urandom_range(0, 43)};
            else             return {$urandom, $urandom};
        end
        case (op)
            3'd3:    lim = 4096;
            3'd5:    lim = 1048576;
            default: lim = 2048;
        endcase
        case (k)
            0: v = longint'({$urandom, $urandom});
            1: v = longint'($urandom_range(0, 32'(2 * lim - 1))) - lim;
            2: begin
                case ($urandom_range(0, 4))
                    0:       v = lim - 1;
                    1:       v = lim - 2;
                    2:       v = -lim;
                    3:       v = lim;
                    default: v = -lim - 1;
                endcase
            end
            default: v = longint'($urandom_range(0, 32'(2 * lim - 1))) - lim;
        endcase
        if ((op == 3'd3 || op == 3'd5) && k == 1) v[0] = 1'b0;
        return 64'(v);
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later, score
    // the output transfer and record the input transfer.
    task automatic cycle(input logic iv, input logic [2:0] op, input logic [63:0] imm,
                         input logic [31:0] base, input logic ordy);
        exp_t e;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.immgen_op = op;
        bus.imm_val   = imm;
        bus.base_inst = base;
        bus.out_ready = ordy;
        #1;
        check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
        check("err_cnt_sat", 64'(err_cnt2), 64'(exp_cnt2));
        check("in_ready", 64'(bus.in_ready), 64'((sb.size() < 2) || ordy));
        if (prev_stall) begin
            check("stall_valid", 64'(bus.out_valid), 64'd1);
            check("stall_inst", 64'(bus.inst), 64'(prev_inst));
            check("stall_err", 64'(bus.range_err), 64'(prev_err));
        end
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(bus.out_valid), 64'd0);
            end else if (ordy) begin
                e = sb.pop_front();
                check("inst", 64'(bus.inst), 64'(e.inst));
                check("range_err", 64'(bus.range_err), 64'(e.err));
                if (!e.err) check("round_trip", decode(e.op, bus.inst), e.imm);
                if (e.err) begin
                    exp_cnt++;
                    if (exp_cnt2 < 3) exp_cnt2++;
                end
            end
        end
        prev_stall = bus.out_valid && !ordy;
        prev_inst  = bus.inst;
        prev_err   = bus.range_err;
        last_acc   = iv && bus.in_ready;
        if (last_acc) sb.push_back(model(op, imm, base));
    endtask

    task automatic idle();
        cycle(1'b0, 3'd0, 64'd0, 32'd0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) idle();
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Single request into an empty pipeline with latency and constant checks.
    task automatic directed(input string tag, input logic [2:0] op, input logic [63:0] imm,
                            input logic [31:0] base, input logic [31:0] exp_inst,
                            input logic exp_err);
        cycle(1'b1, op, imm, base, 1'b1);
        check({tag, "_accept"}, 64'(last_acc), 64'd1);
        idle();
        check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        idle();
        check({tag, "_lat2"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_inst"}, 64'(bus.inst), 64'(exp_inst));
        check({tag, "_err"}, 64'(bus.range_err), 64'(exp_err));
    endtask

    logic [2:0]  p_op;
    logic [63:0] p_imm;
    logic [31:0] p_base;
    logic        p_have;
    int          sent;
    int          cyc;

    initial begin
        bus.in_valid  = 1'b0;
        bus.immgen_op = 3'd0;
        bus.imm_val   = 64'd0;
        bus.base_inst = 32'd0;
        bus.out_ready = 1'b0;

        // Reset state.
        #2 rstn = 1'b0;
        #6;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_inst", 64'(bus.inst), 64'd0);
        check("rst_range_err", 64'(bus.range_err), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // I format at its negative limit, 2-cycle latency.
        directed("i_min", 3'd1, 64'hFFFF_FFFF_FFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
        drain();

        // B odd immediate, then J just out of range.
        directed("b_odd", 3'd3, 64'd4097, 32'h0000_0063, 32'h8000_0063, 1'b1);
        idle();
        check("b_odd_err_cnt", 64'(err_cnt), 64'd1);
        directed("j_range", 3'd5, 64'h0000_0000_0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1);
        drain();

        // U format: clean upper immediate, then one with a low bit set.
        directed("u_ok", 3'd4, 64'h1234_5000_0000_0000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        directed("u_low", 3'd4, 64'h1234_5000_0000_0001, 32'h0000_0037, 32'h1234_5037, 1'b1);
        drain();

        // Eight back-to-back requests with out_ready pattern 1,0,0 repeating.
        sent   = 0;
        cyc    = 0;
        p_have = 1'b0;
        while (sent < 8 && cyc < 80) begin
            if (!p_have) begin
                p_op   = 3'($urandom_range(1, 5));
                p_imm  = gen_imm(p_op);
                p_base = $urandom;
                p_have = 1'b1;
            end
            cycle(1'b1, p_op, p_imm, p_base, (cyc % 3) == 0);
            if (last_acc) begin
                sent++;
                p_have = 1'b0;
            end
            cyc++;
        end
        check("b2b_sent", 64'(sent), 64'd8);
        drain();

        // Reset with two requests held under stall.
        cycle(1'b1, 3'd3, 64'd1, 32'h0000_0063, 1'b0);
        cycle(1'b1, 3'd5, 64'd3, 32'h0000_006F, 1'b0);
        idle_stalled: begin
            cycle(1'b0, 3'd0, 64'd0, 32'd0, 1'b0);
        end
        check("held_two_valid", 64'(bus.out_valid), 64'd1);
        check("pre_rst_err_cnt_nz", 64'(err_cnt != 16'd0), 64'd1);
        rstn = 1'b0;
        #1;
        check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst2_err_cnt", 64'(err_cnt), 64'd0);
        check("rst2_err_cnt_sat", 64'(err_cnt2), 64'd0);
        check("rst2_inst", 64'(bus.inst), 64'd0);
        check("rst2_range_err", 64'(bus.range_err), 64'd0);
        sb.delete();
        exp_cnt    = 0;
        exp_cnt2   = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            check("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
        end

        // Five errored results: 16-bit counter reads 5, 2-bit counter holds at 3.
        for (int i = 0; i < 5; i++) cycle(1'b1, 3'd7, {$urandom, $urandom}, $urandom, 1'b1);
        drain();
        idle();
        check("sat_err_cnt2", 64'(err_cnt2), 64'd3);
        check("sat_err_cnt", 64'(err_cnt), 64'd5);

        // Randomized sweep over all op codes with random valid/ready.
        p_have = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!p_have) begin
                p_op   = 3'($urandom_range(0, 7));
                p_imm  = gen_imm(p_op);
                p_base = $urandom;
                p_have = 1'b1;
            end
            cycle($urandom_range(0, 3) != 0, p_op, p_imm, p_base, $urandom_range(0, 9) < 7);
            if (last_acc) p_have = 1'b0;
        end
        drain();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 Parameter ERR_CNT_W, default 16: width of the saturating error counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  encoder can accept a request this cycle.
REQ-006 immgen_op  input  3  format: 001 I, 010 S, 011 B, 100 U, 101 J; all other codes invalid.
REQ-007 imm_val  input  64  immediate to encode, in the codebase immediate layout.
REQ-008 base_inst  input  32  template supplying every non-immediate bit (opcode, rd, rs1, rs2, funct).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 inst  output  32  encoded instruction.
REQ-012 range_err  output  1  imm_val not representable, or op invalid; qualified by out_valid.
REQ-013 err_cnt  output  ERR_CNT_W  count of results delivered with range_err=1.

Function
REQ-014 Handshake: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
REQ-015 Two-stage pipeline: S1 registers op/imm/base; S2 registers inst and range_err; latency from input transfer to out_valid is exactly 2 cycles when no stall.
REQ-016 A stage advances when it holds data and the next stage is empty or transferring that cycle; in_ready = !s1_valid || s1 advances; sustained throughput is 1 per cycle with out_ready=1.
REQ-017 Under out_ready=0 the pipeline holds up to 2 requests; inst/range_err stay stable while out_valid=1 and not accepted; no request is lost or duplicated.
REQ-018 I: inst[31:20]=imm[11:0]; error unless imm[63:11] are all equal.
REQ-019 S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]; error unless imm[63:11] are all equal.
REQ-020 B: inst[31]=imm[12], inst[7]=imm[11], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1]; error if imm[0]=1 or imm[63:12] are not all equal.
REQ-021 U: inst[31:12]=imm[63:44]; error if imm[43:0]!=0.
REQ-022 J: inst[31]=imm[20], inst[19:12]=imm[19:12], inst[20]=imm[11], inst[30:21]=imm[10:1]; error if imm[0]=1 or imm[63:20] are not all equal.
REQ-023 Bits not listed for the format come from base_inst; on error the listed fields still take the truncated imm bits.
REQ-024 Invalid op: inst=base_inst, range_err=1.
REQ-025 Round trip: for any request with range_err=0, decoding inst with the same immgen_op through the team immediate generator returns imm_val exactly.
REQ-026 err_cnt increments by 1 on each output transfer with range_err=1 and saturates at all-ones; it does not wrap.

Reset
REQ-027 rstn=0 immediately clears S1/S2 valid; out_valid=0, inst=0, range_err=0, err_cnt=0; in_ready=1 from the first edge after release.
REQ-028 Requests in flight when reset asserts are discarded; no partial result appears after release.

Verification
REQ-029 I, imm=64'hFFFF_FFFF_FFFF_F800, base=32'h0000_0013 -> inst=32'h8000_0013, range_err=0, out_valid 2 cycles after accept.
REQ-030 B, imm=64'd4097 -> range_err=1 (odd), err_cnt 0->1; J, imm=64'h0010_0000 -> range_err=1 (out of range).
REQ-031 U, imm=64'h1234_5000_0000_0000, base=32'h0000_0037 -> inst=32'h1234_5037, range_err=0; imm low bit 0 set -> range_err=1.
REQ-032 Back-to-back 8 requests with out_ready toggled 1,0,0,1,... -> results in order, in_ready=0 only while 2 are held, and each output is stable while stalled.
REQ-033 rstn asserted with 2 requests held -> out_valid=0 and err_cnt=0 at once; no stale output after release.
REQ-034 Random sweep of all formats -> every range_err=0 result round-trips per REQ-025; ERR_CNT_W=2 with 5 errors -> err_cnt holds at 3.
